// File: rtl/board_pixel_decoder.sv
// Maps a screen pixel to the 8x8 board cell under it by repeated subtraction of the
// cell pitch on both axes, reporting in-cell offset, outline hit, square colour and off-board.
module board_pixel_decoder #(
    parameter int BOARD_ORIGIN = 8,
    parameter int CELL_PITCH   = 28,
    parameter int BOARD_CELLS  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [8:0] pix_x,
    input  logic [7:0] pix_y,
    output logic       busy,
    output logic       done,
    output logic [2:0] cell_x,
    output logic [2:0] cell_y,
    output logic [4:0] offset_x,
    output logic [4:0] offset_y,
    output logic       on_border,
    output logic       cell_colour,
    output logic       off_board
);

    typedef enum logic [1:0] {S_IDLE, S_OFFSET, S_DIVIDE, S_DONE} state_t;

    localparam logic [2:0] LAST_CELL = 3'(BOARD_CELLS - 1);
    localparam logic [4:0] EDGE_OFF  = 5'(CELL_PITCH - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [8:0] r_rx;
    logic [7:0] r_ry;
    logic [2:0] r_cx;
    logic [2:0] r_cy;

    logic [2:0] r_cell_x;
    logic [2:0] r_cell_y;
    logic [4:0] r_off_x;
    logic [4:0] r_off_y;
    logic       r_on_border;
    logic       r_cell_colour;
    logic       r_off_board;

    logic w_low;
    logic w_x_ge;
    logic w_y_ge;
    logic w_ovf;
    logic w_fit;
    logic w_border;
    logic w_colour;

    assign w_low    = (r_rx < 9'(BOARD_ORIGIN)) || (r_ry < 8'(BOARD_ORIGIN));
    assign w_x_ge   = (r_rx >= 9'(CELL_PITCH));
    assign w_y_ge   = (r_ry >= 8'(CELL_PITCH));
    assign w_ovf    = (w_x_ge && (r_cx == LAST_CELL)) || (w_y_ge && (r_cy == LAST_CELL));
    assign w_fit    = !w_x_ge && !w_y_ge;
    assign w_border = (r_rx[4:0] == 5'd0) || (r_rx[4:0] == EDGE_OFF) ||
                      (r_ry[4:0] == 5'd0) || (r_ry[4:0] == EDGE_OFF);
    assign w_colour = ~(r_cx[0] ^ r_cy[0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_rx          <= '0;
            r_ry          <= '0;
            r_cx          <= '0;
            r_cy          <= '0;
            r_cell_x      <= '0;
            r_cell_y      <= '0;
            r_off_x       <= '0;
            r_off_y       <= '0;
            r_on_border   <= 1'b0;
            r_cell_colour <= 1'b0;
            r_off_board   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rx <= pix_x;
                        r_ry <= pix_y;
                    end
                end
                S_OFFSET: begin
                    r_rx <= r_rx - 9'(BOARD_ORIGIN);
                    r_ry <= r_ry - 8'(BOARD_ORIGIN);
                    r_cx <= '0;
                    r_cy <= '0;
                    if (w_low) begin
                        r_cell_x      <= '0;
                        r_cell_y      <= '0;
                        r_off_x       <= '0;
                        r_off_y       <= '0;
                        r_on_border   <= 1'b0;
                        r_cell_colour <= 1'b0;
                        r_off_board   <= 1'b1;
                    end
                end
                S_DIVIDE: begin
                    if (w_ovf) begin
                        r_cell_x      <= '0;
                        r_cell_y      <= '0;
                        r_off_x       <= '0;
                        r_off_y       <= '0;
                        r_on_border   <= 1'b0;
                        r_cell_colour <= 1'b0;
                        r_off_board   <= 1'b1;
                    end else if (w_fit) begin
                        r_cell_x      <= r_cx;
                        r_cell_y      <= r_cy;
                        r_off_x       <= r_rx[4:0];
                        r_off_y       <= r_ry[4:0];
                        r_on_border   <= w_border;
                        r_cell_colour <= w_colour;
                        r_off_board   <= 1'b0;
                    end else begin
                        // Axes advance independently; the finished axis simply idles
                        if (w_x_ge) begin
                            r_rx <= r_rx - 9'(CELL_PITCH);
                            r_cx <= r_cx + 3'd1;
                        end
                        if (w_y_ge) begin
                            r_ry <= r_ry - 8'(CELL_PITCH);
                            r_cy <= r_cy + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_next = S_OFFSET;
            S_OFFSET: w_state_next = w_low ? S_DONE : S_DIVIDE;
            S_DIVIDE: if (w_ovf || w_fit) w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state != S_IDLE);
        done        = (r_state == S_DONE);
        cell_x      = r_cell_x;
        cell_y      = r_cell_y;
        offset_x    = r_off_x;
        offset_y    = r_off_y;
        on_border   = r_on_border;
        cell_colour = r_cell_colour;
        off_board   = r_off_board;
    end

endmodule

// File: tb/tb_board_pixel_decoder.sv
// Scoreboard bench: the driver queues expected results from an arithmetic model,
// a monitor checks each done pulse, its timing, and that results hold in between.
module tb_board_pixel_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [8:0] pix_x;
    logic [7:0] pix_y;
    logic       busy;
    logic       done;
    logic [2:0] cell_x;
    logic [2:0] cell_y;
    logic [4:0] offset_x;
    logic [4:0] offset_y;
    logic       on_border;
    logic       cell_colour;
    logic       off_board;

    board_pixel_decoder dut (
        .clk(clk), .reset(reset), .start(start), .pix_x(pix_x), .pix_y(pix_y),
        .busy(busy), .done(done), .cell_x(cell_x), .cell_y(cell_y),
        .offset_x(offset_x), .offset_y(offset_y), .on_border(on_border),
        .cell_colour(cell_colour), .off_board(off_board)
    );

    always #5 clk = ~clk;

    typedef struct {
        int edge_n;
        int x, y;
        int cx, cy, ox, oy, bord, col, off;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t zero_exp();
        exp_t e;
        e = '{edge_n: 0, x: 0, y: 0, cx: 0, cy: 0, ox: 0, oy: 0, bord: 0, col: 0, off: 0};
        return e;
    endfunction

    // Reference: direct division of the board-relative coordinate by the pitch.
    function automatic exp_t model(int x, int y, int now);
        exp_t e;
        int   lat;
        e = zero_exp();
        e.x = x;
        e.y = y;
        if (x < 8 || y < 8) begin
            e.off = 1;
            lat   = 2;
        end else if (x > 231 || y > 231) begin
            e.off = 1;
            lat   = 10;
        end else begin
            e.cx   = (x - 8) / 28;
            e.cy   = (y - 8) / 28;
            e.ox   = (x - 8) % 28;
            e.oy   = (y - 8) % 28;
            e.bord = (e.ox == 0 || e.ox == 27 || e.oy == 0 || e.oy == 27) ? 1 : 0;
            e.col  = ((e.cx + e.cy) % 2 == 0) ? 1 : 0;
            lat    = 3 + ((e.cx > e.cy) ? e.cx : e.cy);
        end
        e.edge_n = now + lat;
        return e;
    endfunction

    task automatic chk(string name, int act, int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic chk_outputs(string tag, exp_t e);
        chk({tag, "_cell_x"}, int'(cell_x), e.cx);
        chk({tag, "_cell_y"}, int'(cell_y), e.cy);
        chk({tag, "_offset_x"}, int'(offset_x), e.ox);
        chk({tag, "_offset_y"}, int'(offset_y), e.oy);
        chk({tag, "_on_border"}, int'(on_border), e.bord);
        chk({tag, "_cell_colour"}, int'(cell_colour), e.col);
        chk({tag, "_off_board"}, int'(off_board), e.off);
    endtask

    initial last = zero_exp();

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk("done_cycle", cyc, e.edge_n);
                chk("busy_at_done", int'(busy), 1);
                chk_outputs("result", e);
                $display("decode (%0d,%0d) -> cell(%0d,%0d) off(%0d,%0d) border=%0d colour=%0d offb=%0d @%0d",
                         e.x, e.y, cell_x, cell_y, offset_x, offset_y, on_border,
                         cell_colour, off_board, cyc);
                last = e;
            end
        end else begin
            chk_outputs("hold", last);
            if (q.size() > 0 && cyc > q[0].edge_n) begin
                chk("done_timeout", cyc, q[0].edge_n);
                void'(q.pop_front());
            end
        end
    end

    task automatic issue(int x, int y);
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("idle_wait", int'(busy), 0);
        pix_x = 9'(x);
        pix_y = 8'(y);
        start = 1'b1;
        q.push_back(model(x, y, cyc));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() > 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        pix_x = '0;
        pix_y = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b0;

        issue(8, 8);
        issue(231, 231);
        issue(50, 70);
        issue(5, 100);
        issue(232, 20);
        issue(511, 255);
        issue(35, 35);
        issue(36, 8);
        issue(100, 7);
        issue(20, 255);
        drain();

        // start pulses while busy must be ignored
        issue(231, 231);
        pix_x = 9'd50;
        pix_y = 8'd70;
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        drain();

        for (int i = 0; i < 150; i++) begin
            if (i % 2 == 0) issue(int'($urandom_range(0, 240)), int'($urandom_range(0, 240)));
            else            issue(int'($urandom_range(0, 511)), int'($urandom_range(0, 255)));
        end
        drain();

        // reset mid-decode: no done may follow
        issue(231, 231);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        q.delete();
        last = zero_exp();
        @(posedge clk);
        #2;
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);

        // start held high: back-to-back decodes
        begin
            int issued = 0;
            int guard  = 0;
            start = 1'b1;
            while (issued < 20 && guard < 400) begin
                pix_x = 9'($urandom_range(0, 250));
                pix_y = 8'($urandom_range(0, 250));
                if (!busy) begin
                    q.push_back(model(int'(pix_x), int'(pix_y), cyc));
                    issued++;
                end
                @(negedge clk);
                guard++;
            end
            start = 1'b0;
            chk("b2b_issued", issued, 20);
        end
        drain();
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
